ofm_tx_sched: RTL and testbench

- Read-side sequencer for the outbound frame FIFO pair (34-bit ctrl/descriptor FIFO plus 73-bit data FIFO) in the tx_clk domain.
- Pops one descriptor per frame, then streams that frame's data words to a registered AXI4-Stream master toward the 10G MAC TX path.
- Discards frames flagged for drop and enforces a minimum inter-frame idle gap.
- Checks descriptor length against summed byte enables and keeps frame/drop/error statistics.

---
 rtl/ofm_tx_sched.sv | 132 +++++++++++++
 tb/tb_ofm_tx_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_tx_sched.sv
// ofm_tx_sched: read-side sequencer for the outbound frame FIFO pair.
// Pops one descriptor per frame, then streams the frame's data words to a
// registered AXI4-Stream master. Frames flagged for drop are discarded.
// A minimum idle gap is kept between frames. The descriptor length is
// checked against the summed byte enables, and frame statistics are counted.
//
// Ports:
//   tx_clk, tx_resetn     clock; asynchronous active-low reset
//   enable                allows new descriptor pops
//   ctrl_fifo_*           show-ahead descriptor FIFO
//                         ([15:0] len, [32] drop, [33] err)
//   data_fifo_*           show-ahead data FIFO
//                         ([63:0] data, [71:64] keep, [72] last)
//   m_axis_*              registered AXI4-Stream master; tuser is valid with tlast
//   len_err               one-cycle pulse on a length mismatch
//   frame_cnt, drop_cnt,  wrapping statistics counters
//   err_cnt
module ofm_tx_sched #(
    parameter int C_IFG   = 1,
    parameter int C_CNT_W = 32
) (
    input  logic               tx_clk,
    input  logic               tx_resetn,
    input  logic               enable,
    input  logic [33:0]        ctrl_fifo_rdata,
    input  logic               ctrl_fifo_empty,
    output logic               ctrl_fifo_rden,
    input  logic [72:0]        data_fifo_rdata,
    input  logic               data_fifo_empty,
    output logic               data_fifo_rden,
    output logic [63:0]        m_axis_tdata,
    output logic [7:0]         m_axis_tkeep,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               len_err,
    output logic [C_CNT_W-1:0] frame_cnt,
    output logic [C_CNT_W-1:0] drop_cnt,
    output logic [C_CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

    localparam logic [C_CNT_W-1:0] cnt_one = 1;

    state_t      state;
    state_t      done_state;
    logic [15:0] len;
    logic        desc_err;
    logic [16:0] acc;
    logic [16:0] sum;
    logic [15:0] gap_cnt;
    logic        mismatch;
    logic        unused_bits;

    assign unused_bits = ^ctrl_fifo_rdata[31:16];
    assign done_state  = (C_IFG > 0) ? GAP : IDLE;

    // Reset is folded in so that no pop strobe leaks out while the block is held in reset.
    assign ctrl_fifo_rden = tx_resetn && state == IDLE && enable && !ctrl_fifo_empty;
    assign data_fifo_rden = !data_fifo_empty &&
                            ((state == XFER && (!m_axis_tvalid || m_axis_tready)) || state == DROP);

    // Bytes of the frame so far, including the word currently at the FIFO head.
    assign sum      = acc + 17'($countones(data_fifo_rdata[71:64]));
    assign mismatch = sum != {1'b0, len};

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            state         <= IDLE;
            len           <= '0;
            desc_err      <= 1'b0;
            acc           <= '0;
            gap_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            len_err       <= 1'b0;
            frame_cnt     <= '0;
            drop_cnt      <= '0;
            err_cnt       <= '0;
        end else begin
            len_err <= 1'b0;
            // Drain a pending beat in any state; a pop in XFER overrides this below.
            if (m_axis_tready)
                m_axis_tvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_fifo_rden) begin
                        len      <= ctrl_fifo_rdata[15:0];
                        desc_err <= ctrl_fifo_rdata[33];
                        acc      <= '0;
                        state    <= ctrl_fifo_rdata[32] ? DROP : XFER;
                    end
                end
                XFER: begin
                    if (data_fifo_rden) begin
                        m_axis_tdata  <= data_fifo_rdata[63:0];
                        m_axis_tkeep  <= data_fifo_rdata[71:64];
                        m_axis_tlast  <= data_fifo_rdata[72];
                        m_axis_tuser  <= data_fifo_rdata[72] & (desc_err | mismatch);
                        m_axis_tvalid <= 1'b1;
                        acc           <= sum;
                        if (data_fifo_rdata[72]) begin
                            frame_cnt <= frame_cnt + cnt_one;
                            len_err   <= mismatch;
                            if (mismatch)
                                err_cnt <= err_cnt + cnt_one;
                            gap_cnt <= 16'(C_IFG);
                            state   <= done_state;
                        end
                    end
                end
                DROP: begin
                    if (data_fifo_rden && data_fifo_rdata[72]) begin
                        drop_cnt <= drop_cnt + cnt_one;
                        gap_cnt  <= 16'(C_IFG);
                        state    <= done_state;
                    end
                end
                GAP: begin
                    if (gap_cnt <= 16'd1)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 16'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ofm_tx_sched.sv
// tb_ofm_tx_sched: self-checking bench for ofm_tx_sched.
// FIFO models feed the DUT. A per-frame scoreboard predicts every beat and
// every statistic.
module tb_ofm_tx_sched;
    localparam int IFG = 2;

    logic        tx_clk = 1'b0;
    logic        tx_resetn = 1'b0;
    logic        enable = 1'b0;
    logic [33:0] ctrl_fifo_rdata;
    logic        ctrl_fifo_empty;
    logic        ctrl_fifo_rden;
    logic [72:0] data_fifo_rdata;
    logic        data_fifo_empty;
    logic        data_fifo_rden;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        len_err;
    logic [31:0] frame_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] err_cnt;
    logic [73:0] beat;

    always #5 tx_clk = ~tx_clk;

    ofm_tx_sched #(.C_IFG(IFG), .C_CNT_W(32)) dut (
        .tx_clk(tx_clk), .tx_resetn(tx_resetn), .enable(enable),
        .ctrl_fifo_rdata(ctrl_fifo_rdata), .ctrl_fifo_empty(ctrl_fifo_empty), .ctrl_fifo_rden(ctrl_fifo_rden),
        .data_fifo_rdata(data_fifo_rdata), .data_fifo_empty(data_fifo_empty), .data_fifo_rden(data_fifo_rden),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .len_err(len_err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    assign beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};

    logic [33:0] ctrl_q[$];
    logic [72:0] data_q[$];
    logic [73:0] exp_q[$];
    int ctrl_pop_cyc[$], last_pop_cyc[$], beat_cyc[$];
    int tests = 0, fails = 0, cyc = 0;
    int beats = 0, vld_cycles = 0, lerr = 0, stalls = 0;
    int m_frames = 0, m_drops = 0, m_errs = 0;
    logic last_user = 1'b0, prev_lerr = 1'b0, stall_prev = 1'b0, chk_stall_pop = 1'b0;
    logic [73:0] held = '0;
    logic [3:0] rdy_pat = 4'hF;
    bit rdy_rand = 1'b0;

    typedef struct {
        int         len;
        bit         drop;
        bit         err;
        int         nw;
        logic [7:0] lkeep;
        int         exp_beats;
        bit         exp_user;
        int         exp_lerr;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic void refresh();
        ctrl_fifo_empty = (ctrl_q.size() == 0);
        ctrl_fifo_rdata = ctrl_fifo_empty ? '0 : ctrl_q[0];
        data_fifo_empty = (data_q.size() == 0);
        data_fifo_rdata = data_fifo_empty ? '0 : data_q[0];
    endfunction

    // Queues one whole frame and predicts its outcome from the frame as a whole.
    // len < 0 means "use the byte-enable total plus off".
    task automatic push_frame(input int len, input int off, input bit drop, input bit err,
                              input int nw, input logic [7:0] lkeep, input bit rk);
        int sum = 0;
        logic [72:0] w;
        logic [15:0] l;
        logic [72:0] words[$];
        for (int i = 0; i < nw; i++) begin
            w[63:0]  = {$urandom, $urandom};
            w[71:64] = (i == nw - 1) ? lkeep : (rk ? 8'($urandom) : 8'hFF);
            w[72]    = (i == nw - 1);
            sum += $countones(w[71:64]);
            words.push_back(w);
        end
        l = (len < 0) ? 16'(sum + off) : 16'(len);
        ctrl_q.push_back({err, drop, 16'($urandom), l});
        foreach (words[i]) data_q.push_back(words[i]);
        if (drop) m_drops++;
        else begin
            m_frames++;
            if (sum != int'(l)) m_errs++;
            foreach (words[i])
                exp_q.push_back({words[i][63:0], words[i][71:64], words[i][72],
                                 words[i][72] & (err | (sum != int'(l)))});
        end
        refresh();
    endtask

    task automatic tick();
        logic c_pop, d_pop;
        @(negedge tx_clk);
        cyc++;
        c_pop = ctrl_fifo_rden;
        d_pop = data_fifo_rden;
        if (c_pop) begin
            check("ctrl_pop_nonempty", ctrl_fifo_empty, 0);
            ctrl_pop_cyc.push_back(cyc);
        end
        if (d_pop) begin
            check("data_pop_nonempty", data_fifo_empty, 0);
            if (data_fifo_rdata[72]) last_pop_cyc.push_back(cyc);
        end
        if (stall_prev) begin
            stalls++;
            check("stall_hold", {m_axis_tvalid, beat}, {1'b1, held});
        end
        if (chk_stall_pop && m_axis_tvalid && !m_axis_tready) check("stall_no_pop", d_pop, 0);
        if (m_axis_tvalid) vld_cycles++;
        if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
            else check("beat", beat, exp_q.pop_front());
            if (m_axis_tlast) last_user = m_axis_tuser;
        end
        if (len_err) begin
            lerr++;
            check("len_err_pulse", prev_lerr, 0);
        end
        prev_lerr  = len_err;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        held       = beat;
        @(posedge tx_clk);
        #1;
        if (c_pop && ctrl_q.size() > 0) void'(ctrl_q.pop_front());
        if (d_pop && data_q.size() > 0) void'(data_q.pop_front());
        m_axis_tready = rdy_rand ? 1'($urandom) : rdy_pat[cyc % 4];
        refresh();
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!(ctrl_q.size() == 0 && data_q.size() == 0 && exp_q.size() == 0 && !m_axis_tvalid) && n < limit) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, n >= limit, 0);
        repeat (4) tick();
    endtask

    initial begin
        logic [31:0] f0, d0, e0;
        int n;
        vecs[0] = '{20, 0, 0, 3, 8'h0F, 3, 0, 0};
        vecs[1] = '{17, 0, 0, 2, 8'hFF, 2, 1, 1};
        vecs[2] = '{32, 1, 0, 4, 8'hFF, 0, 0, 0};
        vecs[3] = '{16, 0, 1, 2, 8'hFF, 2, 1, 0};
        vecs[4] = '{0,  0, 0, 1, 8'h00, 1, 0, 0};
        vecs[5] = '{0,  0, 0, 1, 8'h01, 1, 1, 1};
        vecs[6] = '{8,  0, 0, 1, 8'hFF, 1, 0, 0};
        vecs[7] = '{3,  1, 1, 2, 8'hFF, 0, 0, 0};
        refresh();
        repeat (2) @(posedge tx_clk);
        @(negedge tx_clk);
        check("reset_ctrl", {ctrl_fifo_rden, data_fifo_rden, m_axis_tvalid, m_axis_tlast, m_axis_tuser, len_err, m_axis_tkeep}, 0);
        check("reset_tdata", m_axis_tdata, 0);
        check("reset_counters", {frame_cnt, drop_cnt, err_cnt}, 0);
        @(posedge tx_clk);
        #1;
        tx_resetn = 1'b1;
        enable    = 1'b1;

        foreach (vecs[i]) begin
            f0 = frame_cnt; d0 = drop_cnt; e0 = err_cnt;
            beats = 0; vld_cycles = 0; lerr = 0; last_user = 1'b0;
            push_frame(vecs[i].len, 0, vecs[i].drop, vecs[i].err, vecs[i].nw, vecs[i].lkeep, 1'b0);
            wait_done("vec", 200);
            check("vec_beats", beats, vecs[i].exp_beats);
            check("vec_valid_cycles", vld_cycles, vecs[i].exp_beats);
            check("vec_last_tuser", last_user, vecs[i].exp_user);
            check("vec_len_err", lerr, vecs[i].exp_lerr);
            check("vec_frame_cnt", frame_cnt - f0, vecs[i].drop ? 0 : 1);
            check("vec_drop_cnt", drop_cnt - d0, vecs[i].drop ? 1 : 0);
            check("vec_err_cnt", err_cnt - e0, vecs[i].exp_lerr);
        end

        // Inter-frame gap and back-to-back beats.
        ctrl_pop_cyc.delete(); last_pop_cyc.delete(); beat_cyc.delete();
        push_frame(20, 0, 0, 0, 3, 8'h0F, 0);
        push_frame(8, 0, 0, 0, 1, 8'hFF, 0);
        wait_done("ifg", 200);
        check("ifg_spacing", (ctrl_pop_cyc.size() >= 2 && last_pop_cyc.size() >= 1) ?
              ctrl_pop_cyc[1] - last_pop_cyc[0] : -1, IFG + 1);
        check("b2b_beats", (beat_cyc.size() >= 3) ? beat_cyc[2] - beat_cyc[0] : -1, 2);

        // Sink stalls with tready pattern 1,0,0,1.
        rdy_pat = 4'b1001; chk_stall_pop = 1'b1; beats = 0; stalls = 0;
        push_frame(20, 0, 0, 0, 3, 8'h0F, 0);
        wait_done("stall", 200);
        check("stall_beats", beats, 3);
        check("stall_seen", stalls > 0, 1);
        chk_stall_pop = 1'b0; rdy_pat = 4'hF;

        // enable dropped after the first data pop of a 5-word frame.
        beats = 0; f0 = frame_cnt; n = 0;
        push_frame(-1, 0, 0, 0, 5, 8'hFF, 0);
        push_frame(-1, 0, 0, 0, 1, 8'h3C, 0);
        while (data_q.size() == 6 && n < 50) begin tick(); n++; end
        check("en_first_pop", data_q.size(), 5);
        enable = 1'b0;
        repeat (40) tick();
        check("en_frame_beats", beats, 5);
        check("en_desc_held", ctrl_q.size(), 1);
        check("en_frame_cnt", frame_cnt - f0, 1);
        enable = 1'b1;
        wait_done("enable", 200);
        check("en_resume_cnt", frame_cnt - f0, 2);
        check("en_resume_beats", beats, 6);

        // Randomised frames with a random sink against the frame-level model.
        rdy_rand = 1'b1; m_frames = 0; m_drops = 0; m_errs = 0; lerr = 0;
        f0 = frame_cnt; d0 = drop_cnt; e0 = err_cnt;
        for (int i = 0; i < 40; i++)
            push_frame(-1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                       int'($urandom_range(1, 6)), 8'($urandom), 1'b1);
        wait_done("random", 5000);
        check("rand_frame_cnt", frame_cnt - f0, m_frames);
        check("rand_drop_cnt", drop_cnt - d0, m_drops);
        check("rand_err_cnt", err_cnt - e0, m_errs);
        check("rand_len_err", lerr, m_errs);
        rdy_rand = 1'b0; rdy_pat = 4'h0;

        // Reset in the middle of a stalled frame.
        push_frame(-1, 0, 0, 0, 5, 8'hFF, 0);
        n = 0;
        while (!m_axis_tvalid && n < 50) begin tick(); n++; end
        check("rst_setup_valid", m_axis_tvalid, 1);
        tx_resetn = 1'b0;
        @(negedge tx_clk);
        check("rst_mid_ctrl", {ctrl_fifo_rden, data_fifo_rden, m_axis_tvalid, m_axis_tlast, m_axis_tuser, len_err, m_axis_tkeep}, 0);
        check("rst_mid_tdata", m_axis_tdata, 0);
        check("rst_mid_counters", {frame_cnt, drop_cnt, err_cnt}, 0);
        ctrl_q.delete(); data_q.delete(); exp_q.delete();
        refresh();
        stall_prev = 1'b0; prev_lerr = 1'b0; rdy_pat = 4'hF; m_axis_tready = 1'b1;
        @(posedge tx_clk);
        #1;
        tx_resetn = 1'b1;
        repeat (2) @(posedge tx_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
